fetch_ctrl: RTL and testbench

//  Sequencer for the fetch stage. Owns the architectural PC register and issues
//  one instruction-memory request at a time. Applies branch redirects from

---
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one instruction-memory request
// at a time, applies execute redirects, drops stale responses and presents
// {pc, instr} to decode behind a valid/stall handshake.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_b_taken,
  input  logic [31:0] i_b_pc,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_counter
);

  typedef enum logic {
    S_REQ  = 1'b0,  // ready to issue a request at pc
    S_WAIT = 1'b1   // one request outstanding, waiting for rvalid
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        drop, drop_nxt;
  logic        valid_nxt;
  logic [31:0] if_pc_nxt, instr_nxt, counter_nxt;
  logic        slot_free, consume;

  // Next-state, handshake and request logic for the fetch sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt   = state;
    pc_nxt      = pc;
    drop_nxt    = drop;
    valid_nxt   = o_if_valid;
    if_pc_nxt   = o_if_pc;
    instr_nxt   = o_if_instr;
    counter_nxt = o_counter;

    // The output slot can take a new instruction when it is empty or is
    // being consumed by decode this cycle.
    slot_free = !o_if_valid || !i_stall;
    consume   = o_if_valid && !i_stall;

    // A redirect masks the request so ack can never coincide with a PC change.
    o_imem_req  = (state == S_REQ) && slot_free && !i_b_taken && !i_reset;
    o_imem_addr = pc;

    if (i_b_taken) begin
      // Redirect wins over stall and capture: flush the held instruction
      // without counting it, and mark any outstanding response as stale.
      pc_nxt    = i_b_pc;
      valid_nxt = 1'b0;
      if (state == S_WAIT) begin
        if (i_imem_rvalid) begin
          drop_nxt  = 1'b0;
          state_nxt = S_REQ;
        end else begin
          drop_nxt  = 1'b1;
        end
      end
    end else begin
      if (consume) begin
        valid_nxt   = 1'b0;
        counter_nxt = o_counter + 32'd1;
      end
      case (state)
        S_REQ: begin
          if (o_imem_req && i_imem_ack) begin
            state_nxt = S_WAIT;
            drop_nxt  = 1'b0;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
            // The slot is always empty in WAIT: a request is only issued
            // when the slot is free, so capture cannot overwrite a held word.
            if (!drop) begin
              valid_nxt = 1'b1;
              if_pc_nxt = pc;
              instr_nxt = i_imem_rdata;
              pc_nxt    = pc + 32'd4;
            end
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // State register with synchronous reset; reset abandons any open request.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the same pre-edge values.
    if (i_reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      o_if_valid <= 1'b0;
      o_if_pc    <= 32'h0;
      o_if_instr <= 32'h0;
      o_counter  <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drop       <= drop_nxt;
      o_if_valid <= valid_nxt;
      o_if_pc    <= if_pc_nxt;
      o_if_instr <= instr_nxt;
      o_counter  <= counter_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a bench-side instruction memory with
// variable latency, directed scenarios followed by random traffic, and a
// transaction-level reference model of the fetch stream.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_reset, i_b_taken, i_stall;
  logic [31:0] i_b_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack, i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_if_valid;
  logic [31:0] o_if_pc, o_if_instr, o_counter;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_b_taken    (i_b_taken),
    .i_b_pc       (i_b_pc),
    .i_stall      (i_stall),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .o_if_valid   (o_if_valid),
    .o_if_pc      (o_if_pc),
    .o_if_instr   (o_if_instr),
    .o_counter    (o_counter)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Bench memory: one outstanding request, latency lat_cfg (0 = random 1..3).
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;
  int          lat_cfg  = 1;

  // Reference model: fetch stream seen as requests and their responses.
  bit          m_known = 1'b0;
  bit          m_inflight, m_live, m_fresh;
  logic [31:0] m_inflight_addr, m_fetch_pc;
  bit          m_valid;
  logic [31:0] m_pc, m_instr, m_count;

  // Observation helpers for directed scenarios.
  bit          last_req = 1'b0;
  logic [31:0] last_acc_addr = 32'hDEAD_BEEF;
  bit          watch_10 = 1'b0;
  bit          saw_10 = 1'b0;

  // Contents of instruction memory: a bijective scramble of the address.
  function automatic logic [31:0] image(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inflight = 1'b0;
    m_live     = 1'b0;
    m_fetch_pc = RESET_PC;
    m_valid    = 1'b0;
    m_pc       = 32'h0;
    m_instr    = 32'h0;
    m_count    = 32'h0;
    m_fresh    = 1'b1;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare just after,
  // then advance memory and model across the rising edge.
  task automatic step(input bit rst, input bit bt, input logic [31:0] bpc,
                      input bit st, input bit ack_en);
    bit          exp_req, rv, acc, deliver, consumed, dut_req;
    logic [31:0] dut_addr, issue_addr;
    rv            = mem_busy && (mem_cnt == 1);
    i_reset       = rst;
    i_b_taken     = bt;
    i_b_pc        = bpc;
    i_stall       = st;
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? image(mem_addr) : $urandom;
    i_imem_ack    = ack_en && !mem_busy;
    #1;
    exp_req = !rst && !m_inflight && (!m_valid || !st) && !bt;
    if (m_known) begin
      check("imem_req", o_imem_req, exp_req);
      if (exp_req) check("imem_addr", o_imem_addr, m_fetch_pc);
      check("if_valid", o_if_valid, m_valid);
      if (m_valid || m_fresh) begin
        check("if_pc", o_if_pc, m_pc);
        check("if_instr", o_if_instr, m_instr);
      end
      check("counter", o_counter, m_count);
    end
    if (watch_10 && o_if_valid && o_if_pc == 32'h10) saw_10 = 1'b1;
    dut_req  = o_imem_req;
    dut_addr = o_imem_addr;
    @(posedge i_clk);
    // Memory side, driven only by what the DUT actually presented.
    last_req = dut_req;
    if (rv) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (dut_req && i_imem_ack) begin
      mem_busy      = 1'b1;
      mem_addr      = dut_addr;
      mem_cnt       = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 3));
      last_acc_addr = dut_addr;
    end
    // Model side.
    if (rst) begin
      model_reset();
      m_known = 1'b1;
    end else begin
      acc        = exp_req && i_imem_ack;
      deliver    = rv && m_inflight;
      consumed   = m_valid && !st;
      issue_addr = m_fetch_pc;
      if (bt) begin
        m_fetch_pc = bpc;
        m_valid    = 1'b0;
        if (deliver) m_inflight = 1'b0;
        else         m_live     = 1'b0;
      end else begin
        if (consumed) begin
          m_valid = 1'b0;
          m_count = m_count + 32'd1;
        end
        if (deliver) begin
          m_inflight = 1'b0;
          if (m_live) begin
            m_valid    = 1'b1;
            m_fresh    = 1'b0;
            m_pc       = m_inflight_addr;
            m_instr    = image(m_inflight_addr);
            m_fetch_pc = m_inflight_addr + 32'd4;
          end
        end
        if (acc) begin
          m_inflight      = 1'b1;
          m_live          = 1'b1;
          m_inflight_addr = issue_addr;
        end
      end
    end
    @(negedge i_clk);
  endtask

  initial begin
    i_reset = 1'b1; i_b_taken = 1'b0; i_b_pc = 32'h0; i_stall = 1'b0;
    i_imem_ack = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);

    // Reset state (checked against the model once reset has been applied).
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);

    // T1: 1-cycle memory, fetch 0, 4, 8 back to back.
    lat_cfg = 1;
    repeat (6) step(0, 0, 0, 0, 1);
    // T2: instruction at 8 held under stall, then released.
    repeat (3) step(0, 0, 0, 1, 1);
    check("t2_held_pc", o_if_pc, 32'h8);
    step(0, 0, 0, 0, 1);
    check("t2_count", o_counter, 32'd3);
    check("t2_next_req", last_acc_addr, 32'hC);

    // T3: redirect while the request for 0x10 is outstanding.
    watch_10 = 1'b1;
    step(0, 0, 0, 0, 1);
    lat_cfg = 2;
    step(0, 0, 0, 0, 1);
    check("t3_req_10", last_acc_addr, 32'h10);
    step(0, 1, 32'h100, 0, 1);
    step(0, 0, 0, 0, 1);
    lat_cfg = 1;
    step(0, 0, 0, 0, 1);
    check("t3_req_100", last_acc_addr, 32'h100);

    // T4: redirect in a REQ cycle masks the request.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h200, 0, 1);
    check("t4_req_masked", last_req, 1'b0);
    step(0, 0, 0, 0, 1);
    check("t4_req_200", last_acc_addr, 32'h200);
    watch_10 = 1'b0;
    check("t3_no_pc_10", saw_10, 1'b0);

    // T5: held instruction flushed by a redirect, counter unchanged.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 1, 32'h300, 1, 1);
    check("t5_flushed", o_if_valid, 1'b0);
    check("t5_count", o_counter, 32'd5);

    // T6: PC wrap from 0xFFFF_FFFC to 0.
    step(0, 1, 32'hFFFF_FFFC, 0, 1);
    step(0, 0, 0, 0, 1);
    check("t6_req_top", last_acc_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("t6_req_wrap", last_acc_addr, 32'h0);

    // T7: reset while waiting; the late response must be ignored.
    step(0, 0, 0, 0, 1);
    lat_cfg = 2;
    step(0, 0, 0, 0, 1);
    check("t7_req_4", last_acc_addr, 32'h4);
    step(1, 0, 0, 0, 1);
    check("t7_count_reset", o_counter, 32'd0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("t7_req_reset_pc", last_acc_addr, RESET_PC);
    repeat (4) step(0, 0, 0, 0, 1);

    // Random traffic against the model.
    lat_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          r_rst, r_bt, r_st, r_ack;
      logic [31:0] r_bpc;
      r_rst = ($urandom_range(0, 199) == 0);
      r_bt  = ($urandom_range(0, 7) == 0);
      r_bpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4)
                                          : $urandom;
      r_st  = ($urandom_range(0, 2) == 0);
      r_ack = ($urandom_range(0, 1) == 0);
      step(r_rst, r_bt, r_bpc, r_st, r_ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
